// File: rtl/par2ser_sel_pkg.sv
// Shared definitions for the two-lane parallel-to-serial front end:
// output FSM encodings and FIFO sizing.
package par2ser_sel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LANE0 = 2'd1,
        LANE1 = 2'd2
    } state_t;

    localparam int         FIFO_DEPTH = 2;
    localparam logic [1:0] CNT_FULL   = 2'd2;
    localparam logic [1:0] CNT_EMPTY  = 2'd0;

endpackage

// File: rtl/par2ser_sel_if.sv
// Handshake bundle for par2ser_sel: upstream word port, downstream lane
// port and status. master = the side feeding words and consuming lanes,
// slave = the serializer itself.
interface par2ser_sel_if #(
    parameter int WIDTH = 1
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2*WIDTH-1:0]   in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_sel;
    logic                 out_last;
    logic                 busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_last, busy
    );
endinterface

// File: rtl/par2ser_sel_mux2x1.sv
// Single-bit 2:1 mux: sel=0 passes a (lane 0), sel=1 passes b (lane 1).
module mux2x1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);
    assign y = sel ? b : a;
endmodule

// File: rtl/par2ser_sel.sv
// Two-lane parallel-to-serial front end. Words are buffered in a 2-entry
// FIFO; an output FSM walks the head word lane 0 then lane 1, one lane per
// accepted output beat, driving the select of a per-bit mux2x1 bank.
module par2ser_sel
    import par2ser_sel_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    par2ser_sel_if.slave  bus
);

    logic [2*WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;
    logic [1:0]         count_nxt;
    state_t             state;
    state_t             state_nxt;

    logic               push;
    logic               beat;
    logic               pop;
    logic               sel;
    logic               vld;
    logic               last;
    logic [2*WIDTH-1:0] head;
    logic [WIDTH-1:0]   lane_y;

    // Ready depends only on registered occupancy, forced low while in reset.
    assign bus.in_ready = (count != CNT_FULL) && rst_n;
    assign push         = bus.in_valid && bus.in_ready;
    assign beat         = vld && bus.out_ready;
    // The word leaves the FIFO only once its second lane is taken.
    assign pop          = beat && (state == LANE1);
    assign count_nxt    = count + {1'b0, push} - {1'b0, pop};

    // FIFO storage and pointers; no bypass, so a pushed word is visible next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= CNT_EMPTY;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= bus.in_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_nxt;
        end
    end

    // Output FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs (no path from out_ready to outputs).
    always_comb begin
        state_nxt = state;
        vld       = 1'b0;
        sel       = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                // Only a push can make the empty FIFO non-empty.
                if (push) begin
                    state_nxt = LANE0;
                end
            end
            LANE0: begin
                vld = 1'b1;
                if (beat) begin
                    state_nxt = LANE1;
                end
            end
            LANE1: begin
                vld  = 1'b1;
                sel  = 1'b1;
                last = 1'b1;
                if (beat) begin
                    state_nxt = (count_nxt != CNT_EMPTY) ? LANE0 : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign head = fifo_mem[rd_ptr];

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        mux2x1 u_mux (
            .a   (head[i]),
            .b   (head[WIDTH+i]),
            .sel (sel),
            .y   (lane_y[i])
        );
    end

    assign bus.out_valid = vld;
    assign bus.out_sel   = sel;
    assign bus.out_last  = last;
    assign bus.out_data  = lane_y;
    assign bus.busy      = (count != CNT_EMPTY);

endmodule

// File: tb/tb_par2ser_sel.sv
// Directed bench for par2ser_sel: a per-cycle vector table for the basic
// word and LANE1 stall, then hand sequences for back-to-back words, FIFO
// fill with downstream stalled, reset mid-word, and a 4-bit lane instance.
module tb_par2ser_sel;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    par2ser_sel_if #(.WIDTH(1)) b1 ();
    par2ser_sel_if #(.WIDTH(4)) b4 ();

    par2ser_sel #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    par2ser_sel #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // iv, d, ordy are stimulus; the rest are expected outputs for that cycle
    typedef struct packed {
        logic       iv;
        logic [1:0] d;
        logic       ordy;
        logic       ov;
        logic       sel;
        logic       last;
        logic       dat;
        logic       bsy;
        logic       ir;
    } vec_t;

    vec_t tbl [12];

    logic [1:0] words [3];
    logic       exp_dat  [6];
    logic       exp_last [6];
    logic       got_dat  [6];
    logic       got_last [6];
    int         nbeat;
    int         idx;
    logic       hold_dat;

    initial begin
        //            iv d  or ov sl la dt bs ir
        tbl[0]  = 10'b1_01_1__0_0_0_0_0_1;
        tbl[1]  = 10'b0_00_1__1_0_0_1_1_1;
        tbl[2]  = 10'b0_00_1__1_1_1_0_1_1;
        tbl[3]  = 10'b0_00_1__0_0_0_0_0_1;
        tbl[4]  = 10'b1_10_1__0_0_0_0_0_1;
        tbl[5]  = 10'b0_00_1__1_0_0_0_1_1;
        tbl[6]  = 10'b0_00_0__1_1_1_1_1_1;
        tbl[7]  = 10'b0_00_0__1_1_1_1_1_1;
        tbl[8]  = 10'b0_00_0__1_1_1_1_1_1;
        tbl[9]  = 10'b0_00_0__1_1_1_1_1_1;
        tbl[10] = 10'b0_00_1__1_1_1_1_1_1;
        tbl[11] = 10'b0_00_1__0_0_0_0_0_1;

        b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
        b4.in_valid = 1'b0; b4.in_data = '0; b4.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", b1.out_valid, 0);
        chk("rst_out_sel",   b1.out_sel,   0);
        chk("rst_out_last",  b1.out_last,  0);
        chk("rst_busy",      b1.busy,      0);
        chk("rst_in_ready",  b1.in_ready,  0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", b1.in_ready, 1);

        // Table: single word 01, then word 10 with a 4-cycle stall on lane 1
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            b1.in_valid  = tbl[i].iv;
            b1.in_data   = tbl[i].d;
            b1.out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("v%0d_out_valid", i), b1.out_valid, tbl[i].ov);
            chk($sformatf("v%0d_out_sel", i),   b1.out_sel,   tbl[i].sel);
            chk($sformatf("v%0d_out_last", i),  b1.out_last,  tbl[i].last);
            chk($sformatf("v%0d_busy", i),      b1.busy,      tbl[i].bsy);
            chk($sformatf("v%0d_in_ready", i),  b1.in_ready,  tbl[i].ir);
            if (tbl[i].ov) chk($sformatf("v%0d_out_data", i), b1.out_data, tbl[i].dat);
        end

        // Back-to-back words 10, 11, 00 with in_valid held, out_ready high
        words[0] = 2'b10; words[1] = 2'b11; words[2] = 2'b00;
        exp_dat  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_last = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        idx = 0; nbeat = 0;
        for (int c = 0; c < 30 && nbeat < 6; c++) begin
            @(negedge clk);
            b1.in_valid  = (idx < 3);
            b1.in_data   = (idx < 3) ? words[idx] : 2'b00;
            b1.out_ready = 1'b1;
            #1;
            if (b1.out_valid) begin
                got_dat[nbeat]  = b1.out_data[0];
                got_last[nbeat] = b1.out_last;
                nbeat++;
            end
            if (b1.in_valid && b1.in_ready) idx++;
        end
        chk("b2b_beats", nbeat, 6);
        for (int k = 0; k < 6; k++) begin
            if (k < nbeat) begin
                chk($sformatf("b2b_dat%0d", k),  got_dat[k],  exp_dat[k]);
                chk($sformatf("b2b_last%0d", k), got_last[k], exp_last[k]);
            end
        end
        @(negedge clk);
        b1.in_valid = 1'b0;
        #1;
        chk("b2b_idle_busy", b1.busy, 0);

        // Downstream stalled: push 01, 10, 11; only two fit
        words[0] = 2'b01; words[1] = 2'b10; words[2] = 2'b11;
        exp_dat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            b1.in_valid  = (idx < 3);
            b1.in_data   = (idx < 3) ? words[idx] : 2'b00;
            b1.out_ready = 1'b0;
            #1;
            if (c == 2) hold_dat = b1.out_data[0];
            if (c > 2) chk($sformatf("stall_stable%0d", c), b1.out_data[0], hold_dat);
            if (b1.in_valid && b1.in_ready) idx++;
        end
        chk("fill_accepted", idx, 2);
        chk("fill_in_ready", b1.in_ready, 0);
        chk("fill_out_valid", b1.out_valid, 1);
        chk("fill_out_sel", b1.out_sel, 0);
        chk("fill_out_data", b1.out_data, 1);
        nbeat = 0;
        for (int c = 0; c < 30 && nbeat < 6; c++) begin
            @(negedge clk);
            b1.in_valid  = (idx < 3);
            b1.in_data   = (idx < 3) ? words[idx] : 2'b00;
            b1.out_ready = 1'b1;
            #1;
            if (b1.out_valid) begin
                got_dat[nbeat]  = b1.out_data[0];
                got_last[nbeat] = b1.out_last;
                nbeat++;
            end
            if (b1.in_valid && b1.in_ready) idx++;
        end
        chk("drain_beats", nbeat, 6);
        for (int k = 0; k < 6; k++) begin
            if (k < nbeat) begin
                chk($sformatf("drain_dat%0d", k),  got_dat[k],  exp_dat[k]);
                chk($sformatf("drain_last%0d", k), got_last[k], (k % 2) == 1);
            end
        end
        @(negedge clk);
        b1.in_valid = 1'b0; b1.out_ready = 1'b0;

        // Reset mid-word while on lane 1
        @(negedge clk);
        b1.in_valid = 1'b1; b1.in_data = 2'b11; b1.out_ready = 1'b1;
        @(negedge clk);
        b1.in_valid = 1'b0;
        @(negedge clk);
        b1.out_ready = 1'b0;
        #1;
        chk("pre_rst_sel", b1.out_sel, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", b1.out_valid, 0);
        chk("mid_rst_out_sel",   b1.out_sel,   0);
        chk("mid_rst_out_last",  b1.out_last,  0);
        chk("mid_rst_busy",      b1.busy,      0);
        chk("mid_rst_in_ready",  b1.in_ready,  0);
        @(negedge clk);
        rst_n = 1'b1;
        b1.in_valid = 1'b1; b1.in_data = 2'b10; b1.out_ready = 1'b1;
        @(negedge clk);
        b1.in_valid = 1'b0;
        #1;
        chk("post_rst_l0_valid", b1.out_valid, 1);
        chk("post_rst_l0_sel",   b1.out_sel,   0);
        chk("post_rst_l0_data",  b1.out_data,  0);
        @(negedge clk);
        #1;
        chk("post_rst_l1_sel",  b1.out_sel,  1);
        chk("post_rst_l1_data", b1.out_data, 1);
        chk("post_rst_l1_last", b1.out_last, 1);

        // 4-bit lanes: A5 -> 5 then A
        @(negedge clk);
        b4.in_valid = 1'b1; b4.in_data = 8'hA5; b4.out_ready = 1'b1;
        @(negedge clk);
        b4.in_valid = 1'b0;
        #1;
        chk("w4_l0_valid", b4.out_valid, 1);
        chk("w4_l0_data",  b4.out_data,  4'h5);
        chk("w4_l0_last",  b4.out_last,  0);
        @(negedge clk);
        #1;
        chk("w4_l1_data", b4.out_data, 4'hA);
        chk("w4_l1_last", b4.out_last, 1);
        @(negedge clk);
        #1;
        chk("w4_idle_valid", b4.out_valid, 0);
        chk("w4_idle_busy",  b4.busy,      0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
